// File: rtl/i2s_line_in_rx.sv
// I2S master-mode line-in receiver: generates MCLK/SCK/LRCK from a 9-bit frame counter,
// deserializes 16-bit stereo samples and hands each pair over through a 1-entry valid/ready buffer.
module i2s_line_in_rx #(
  parameter int unsigned DISCARD_FRAMES = 4,
  parameter logic [3:0]  SAMPLE_PHASE   = 4'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        adc_sdout,
  output logic        adc_mclk,
  output logic        adc_lrck,
  output logic        adc_sck,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  input  logic        overrun_clr
);

  localparam int unsigned CNT_W    = 9;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DISC_W   = 4;
  localparam int unsigned SLOT_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]   left_sr_q, left_sr_d;
  logic [SAMPLE_W-1:0]   right_sr_q, right_sr_d;
  logic [SAMPLE_W-1:0]   left_q, left_d;
  logic [SAMPLE_W-1:0]   right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  skip_q, skip_d;
  logic [DISC_W-1:0]     disc_q, disc_d;

  logic [SLOT_W-1:0]     slot_c;
  logic                  capture_c;
  logic                  frame_evt_c;
  logic                  load_c;
  logic                  accept_c;

  assign slot_c      = cnt_q[8:4];
  assign capture_c   = enable && (state_q != IDLE) && (cnt_q[3:0] == SAMPLE_PHASE);
  assign frame_evt_c = capture_c && (slot_c == SLOT_W'(0));
  assign accept_c    = valid_q && sample_ready;

  assign adc_mclk     = cnt_q[1];
  assign adc_sck      = cnt_q[3];
  assign adc_lrck     = cnt_q[8];
  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PRIME;
        PRIME:   if (frame_evt_c && !skip_q && (disc_q == DISC_W'(DISCARD_FRAMES - 1)))
                   state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: settling-frame bookkeeping and buffer load strobe
  always_comb begin
    disc_d = disc_q;
    skip_d = skip_q;
    load_c = 1'b0;
    if (!enable) begin
      disc_d = '0;
      skip_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          disc_d = '0;
          skip_d = 1'b1;
        end
        PRIME: begin
          // first slot-0 after enable carries no sample, so it is not counted
          if (frame_evt_c) begin
            if (skip_q) skip_d = 1'b0;
            else        disc_d = DISC_W'(disc_q + DISC_W'(1));
          end
        end
        RUN:     load_c = frame_evt_c;
        default: load_c = 1'b0;
      endcase
    end
  end

  // Counter, deserializer and output buffer
  always_comb begin
    cnt_d      = enable ? CNT_W'(cnt_q + CNT_W'(1)) : '0;
    left_sr_d  = left_sr_q;
    right_sr_d = right_sr_q;
    left_d     = left_q;
    right_d    = right_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    if (!enable) begin
      left_sr_d  = '0;
      right_sr_d = '0;
    end else if (capture_c) begin
      if ((slot_c >= SLOT_W'(1)) && (slot_c <= SLOT_W'(16)))
        left_sr_d = {left_sr_q[SAMPLE_W-2:0], adc_sdout};
      else
        right_sr_d = {right_sr_q[SAMPLE_W-2:0], adc_sdout};
    end

    if (overrun_clr) overrun_d = 1'b0;
    if (load_c) begin
      // pair is complete once right[0] lands in slot 0
      left_d  = left_sr_q;
      right_d = right_sr_d;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (accept_c) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      left_sr_q  <= '0;
      right_sr_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      skip_q     <= 1'b1;
      disc_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      left_sr_q  <= left_sr_d;
      right_sr_q <= right_sr_d;
      left_q     <= left_d;
      right_q    <= right_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      skip_q     <= skip_d;
      disc_q     <= disc_d;
    end
  end

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Bench for i2s_line_in_rx: an ADC model serializes per-frame random/directed stereo words in I2S
// timing; deliveries are checked against the frame table, with clock, backpressure and enable-drop steps.
module tb_i2s_line_in_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adc_sdout;
  logic        adc_mclk, adc_lrck, adc_sck;
  logic [15:0] sample_left, sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;

  int tests = 0;
  int fails = 0;

  // ADC-side view of the frame: position within frame and frame number since enable
  int tb_cnt;
  int tb_frame;
  logic [15:0] fl [64];
  logic [15:0] fr [64];

  i2s_line_in_rx dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .adc_sdout    (adc_sdout),
    .adc_mclk     (adc_mclk),
    .adc_lrck     (adc_lrck),
    .adc_sck      (adc_sck),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst || !enable) begin
      tb_cnt   <= 0;
      tb_frame <= 0;
    end else if (tb_cnt == 511) begin
      tb_cnt   <= 0;
      tb_frame <= tb_frame + 1;
    end else begin
      tb_cnt <= tb_cnt + 1;
    end
  end

  // ADC model: left in slots 1..16, right[15:1] in 17..31, right[0] in slot 0 of the next frame
  always @(negedge clk) begin
    int slot;
    logic [15:0] w;
    slot = tb_cnt / 16;
    if (!enable) begin
      adc_sdout = 1'($urandom);
    end else if (slot >= 1 && slot <= 16) begin
      w = fl[tb_frame % 64];
      adc_sdout = w[4'(16 - slot)];
    end else if (slot >= 17) begin
      w = fr[tb_frame % 64];
      adc_sdout = w[4'(32 - slot)];
    end else if (tb_frame > 0) begin
      w = fr[(tb_frame - 1) % 64];
      adc_sdout = w[0];
    end else begin
      adc_sdout = 1'($urandom);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      fl[i] = 16'($urandom);
      fr[i] = 16'($urandom);
    end
  endtask

  initial begin
    int n, k, c, bad;
    int err_m, err_s, err_l, lr_rise, lr_high;
    logic prev_lr;

    rst = 1'b1; enable = 1'b1; adc_sdout = 1'b0; sample_ready = 1'b0; overrun_clr = 1'b0;
    fill_random();
    repeat (3) step();
    chk("rst_left", 32'(sample_left), 32'h0);
    chk("rst_right", 32'(sample_right), 32'h0);
    chk("rst_valid", 32'(sample_valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_clocks", 32'({adc_mclk, adc_sck, adc_lrck}), 32'h0);

    // Idle with enable low: clocks must not move
    enable = 1'b0;
    rst = 1'b0;
    bad = 0;
    repeat (2000) begin
      step();
      if (adc_mclk || adc_sck || adc_lrck || sample_valid) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'h0);

    // Stream: directed words for frames 0..10, random elsewhere
    for (int i = 0; i <= 6; i++) begin fl[i] = 16'hA5C3; fr[i] = 16'h1234; end
    fl[7] = 16'h8000; fr[7] = 16'h7FFF;
    fl[8] = 16'h0000; fr[8] = 16'hFFFF;
    fl[9] = 16'h8000; fr[9] = 16'h7FFF;
    fl[10] = 16'h0000; fr[10] = 16'hFFFF;

    sample_ready = 1'b1;
    enable = 1'b1;
    n = 0; k = 0;
    err_m = 0; err_s = 0; err_l = 0; lr_rise = -1; lr_high = 0; prev_lr = 1'b0;
    while (n < 6144) begin
      step();
      n++;
      c = n % 512;
      if (n <= 1024) begin
        if (adc_mclk !== 1'((c >> 1) & 1)) err_m++;
        if (adc_sck  !== 1'((c >> 3) & 1)) err_s++;
        if (adc_lrck !== 1'((c >> 8) & 1)) err_l++;
        if (!prev_lr && adc_lrck && lr_rise < 0) lr_rise = c;
        if (n <= 512 && adc_lrck) lr_high++;
        prev_lr = adc_lrck;
      end
      if (sample_valid && k < 8) begin
        chk("dly_time", 32'(n), 32'(2572 + 512 * k));
        chk("dly_left", 32'(sample_left), 32'(fl[4 + k]));
        chk("dly_right", 32'(sample_right), 32'(fr[4 + k]));
        k++;
      end
    end
    chk("dly_count", 32'(k), 32'd7);
    chk("mclk_wave", 32'(err_m), 32'h0);
    chk("sck_wave", 32'(err_s), 32'h0);
    chk("lrck_wave", 32'(err_l), 32'h0);
    chk("lrck_rise_cnt", 32'(lr_rise), 32'd256);
    chk("lrck_duty", 32'(lr_high), 32'd256);
    chk("stream_overrun", 32'(overrun), 32'h0);

    // Backpressure across two loads
    sample_ready = 1'b0;
    while (n < 6160) begin step(); n++; end
    chk("bp1_valid", 32'(sample_valid), 32'h1);
    chk("bp1_overrun", 32'(overrun), 32'h0);
    chk("bp1_left", 32'(sample_left), 32'(fl[11]));
    while (n < 6669) begin step(); n++; end
    chk("bp2_valid", 32'(sample_valid), 32'h1);
    chk("bp2_overrun", 32'(overrun), 32'h1);
    chk("bp2_left", 32'(sample_left), 32'(fl[12]));
    chk("bp2_right", 32'(sample_right), 32'(fr[12]));
    overrun_clr = 1'b1;
    step(); n++;
    overrun_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);
    chk("ovr_clr_valid", 32'(sample_valid), 32'h1);

    // Accept in the exact load cycle
    while (n < 7179) begin step(); n++; end
    sample_ready = 1'b1;
    step(); n++;
    chk("coinc_valid", 32'(sample_valid), 32'h1);
    chk("coinc_overrun", 32'(overrun), 32'h0);
    chk("coinc_left", 32'(sample_left), 32'(fl[13]));
    chk("coinc_right", 32'(sample_right), 32'(fr[13]));
    step(); n++;
    chk("coinc_accept", 32'(sample_valid), 32'h0);
    sample_ready = 1'b0;

    // Enable drop with cnt = 300 while a pair is held
    while (n < 7980) begin step(); n++; end
    chk("pre_drop_left", 32'(sample_left), 32'(fl[14]));
    enable = 1'b0;
    step();
    chk("drop_clocks", 32'({adc_mclk, adc_sck, adc_lrck}), 32'h0);
    chk("drop_valid", 32'(sample_valid), 32'h1);
    chk("drop_pair", {sample_left, sample_right}, {fl[14], fr[14]});
    bad = 0;
    repeat (20) begin
      step();
      if (adc_mclk || adc_sck || adc_lrck) bad++;
    end
    chk("drop_quiet", 32'(bad), 32'h0);
    sample_ready = 1'b1;
    step();
    chk("drop_accept", 32'(sample_valid), 32'h0);

    // Re-enable: discard sequence restarts
    fill_random();
    enable = 1'b1;
    n = 0; k = 0;
    while (n < 3210) begin
      step();
      n++;
      if (sample_valid && k < 3) begin
        chk("re_time", 32'(n), 32'(2572 + 512 * k));
        chk("re_pair", {sample_left, sample_right}, {fl[4 + k], fr[4 + k]});
        k++;
      end
    end
    chk("re_count", 32'(k), 32'd2);

    // Asynchronous reset mid-frame
    rst = 1'b1;
    #2;
    chk("arst_clocks", 32'({adc_mclk, adc_sck, adc_lrck}), 32'h0);
    chk("arst_pair", {sample_left, sample_right}, 32'h0);
    chk("arst_valid", 32'(sample_valid), 32'h0);
    step();
    rst = 1'b0;
    enable = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
